// File: rtl/reg_display_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display:
// digits 3..2 show the selected register number, digits 1..0 the debug byte.
module reg_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       disp_en,
  input  logic [4:0] user_addr,
  input  logic [1:0] reg_bits,
  input  logic [7:0] byte_in,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]       SEG_OFF  = 7'h7F;

  // Active-low gfedcba encoding of one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'h40;
      4'h1:    hex7 = 7'h79;
      4'h2:    hex7 = 7'h24;
      4'h3:    hex7 = 7'h30;
      4'h4:    hex7 = 7'h19;
      4'h5:    hex7 = 7'h12;
      4'h6:    hex7 = 7'h02;
      4'h7:    hex7 = 7'h78;
      4'h8:    hex7 = 7'h00;
      4'h9:    hex7 = 7'h10;
      4'hA:    hex7 = 7'h08;
      4'hB:    hex7 = 7'h03;
      4'hC:    hex7 = 7'h46;
      4'hD:    hex7 = 7'h21;
      4'hE:    hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [4:0]       shadow_addr;
  logic [1:0]       shadow_bits;
  logic [7:0]       shadow_byte;

  logic       tick;
  logic       frame_start;
  logic [1:0] idx_nxt;
  logic [4:0] addr_sel;
  logic [1:0] bits_sel;
  logic [7:0] byte_sel;
  logic [3:0] an_nxt;
  logic [6:0] seg_nxt;
  logic       dp_nxt;

  // Stage p0: next digit decode; at frame start the fresh inputs bypass the shadow
  always_comb begin
    tick        = (cnt == CNT_LAST);
    idx_nxt     = idx + 2'd1;
    frame_start = tick && (idx == 2'd3);
    addr_sel    = frame_start ? user_addr : shadow_addr;
    bits_sel    = frame_start ? reg_bits  : shadow_bits;
    byte_sel    = frame_start ? byte_in   : shadow_byte;
    an_nxt      = 4'b1111;
    seg_nxt     = SEG_OFF;
    dp_nxt      = 1'b1;
    if (disp_en) begin
      case (idx_nxt)
        2'd0: begin
          an_nxt  = 4'b1110;
          seg_nxt = hex7(byte_sel[3:0]);
          dp_nxt  = (bits_sel != 2'd3);
        end
        2'd1: begin
          an_nxt  = 4'b1101;
          seg_nxt = hex7(byte_sel[7:4]);
        end
        2'd2: begin
          an_nxt  = 4'b1011;
          seg_nxt = hex7(addr_sel[3:0]);
          dp_nxt  = 1'b0;
        end
        default: begin
          // Leading-zero suppression: the top digit is only ever '1' or blank
          if (addr_sel[4]) begin
            an_nxt  = 4'b0111;
            seg_nxt = 7'h79;
          end
        end
      endcase
    end
  end

  // Stage p1: prescaler, scan index, frame snapshot and registered outputs
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      idx         <= 2'd3;
      shadow_addr <= '0;
      shadow_bits <= '0;
      shadow_byte <= '0;
      an          <= 4'b1111;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) begin
        idx <= idx_nxt;
        an  <= an_nxt;
        seg <= seg_nxt;
        dp  <= dp_nxt;
        if (frame_start) begin
          shadow_addr <= user_addr;
          shadow_bits <= reg_bits;
          shadow_byte <= byte_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_display_driver.sv
// Bench for reg_display_driver: a cycle-count based reference pushes the
// expected {an,seg,dp} for every clock into a scoreboard queue.
module tb_reg_display_driver;

  localparam int DIV = 4;
  localparam logic [11:0] BLANK = {4'b1111, 7'h7F, 1'b1};

  logic       CLK = 1'b0;
  logic       reset;
  logic       disp_en;
  logic [4:0] user_addr;
  logic [1:0] reg_bits;
  logic [7:0] byte_in;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  always #5 CLK = ~CLK;

  reg_display_driver #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
    .CLK(CLK), .reset(reset), .disp_en(disp_en), .user_addr(user_addr),
    .reg_bits(reg_bits), .byte_in(byte_in), .an(an), .seg(seg), .dp(dp)
  );

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_checks = 0;
  int n_pass   = 0;
  int e;
  int m_digit;
  bit m_tick;
  logic [4:0]  s_addr;
  logic [1:0]  s_bits;
  logic [7:0]  s_byte;
  logic [11:0] cur_exp, exp_v, got_v;
  logic [11:0] sb [$];

  function automatic logic [11:0] model_out(int d, logic en, logic [4:0] a,
                                            logic [1:0] b, logic [7:0] by);
    if (!en) return BLANK;
    case (d)
      0:       return {4'b1110, hex_tab[by[3:0]], (b == 2'd3) ? 1'b0 : 1'b1};
      1:       return {4'b1101, hex_tab[by[7:4]], 1'b1};
      2:       return {4'b1011, hex_tab[a[3:0]], 1'b0};
      default: return a[4] ? {4'b0111, 7'h79, 1'b1} : BLANK;
    endcase
  endfunction

  task automatic model_reset();
    e = 0; m_digit = -1; m_tick = 0;
    s_addr = '0; s_bits = '0; s_byte = '0;
    cur_exp = BLANK;
    sb.delete();
  endtask

  // Digit slot k = edges/DIV since reset release; slot 0 is the blank lead-in
  task automatic step();
    e++;
    m_tick = (e % DIV) == 0;
    if (m_tick) begin
      m_digit = ((e / DIV) - 1) % 4;
      if (m_digit == 0) begin
        s_addr = user_addr; s_bits = reg_bits; s_byte = byte_in;
      end
      cur_exp = model_out(m_digit, disp_en, s_addr, s_bits, s_byte);
    end
    sb.push_back(cur_exp);
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; disp_en = 1'b1; user_addr = 5'h13; reg_bits = 2'd0; byte_in = 8'hA5;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if (an !== 4'b1111) $display("FAIL reset_an: got %b want 1111", an); else n_pass++;
    n_checks++;
    if (seg !== 7'h7F) $display("FAIL reset_seg: got %h want 7f", seg); else n_pass++;
    n_checks++;
    if (dp !== 1'b1) $display("FAIL reset_dp: got %b want 1", dp); else n_pass++;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_scan();
    for (int i = 0; i < 20; i++) begin
      step();
      got_v = {an, seg, dp}; exp_v = sb.pop_front(); n_checks++;
      if (got_v !== exp_v)
        $display("FAIL scan e=%0d: got an/seg/dp %b/%h/%b want %b/%h/%b",
                 e, an, seg, dp, exp_v[11:8], exp_v[7:1], exp_v[0]);
      else n_pass++;
      if (e == 3 || e == 4 || e == 12 || e == 16) begin
        n_checks++;
        if ((e == 3  && {an, seg} !== {4'b1111, 7'h7F}) ||
            (e == 4  && {an, seg} !== {4'b1110, 7'h12}) ||
            (e == 12 && {an, seg, dp} !== {4'b1011, 7'h30, 1'b0}) ||
            (e == 16 && {an, seg} !== {4'b0111, 7'h79}))
          $display("FAIL scan_fixed e=%0d: got an/seg/dp %b/%h/%b", e, an, seg, dp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_leading_zero();
    int seen = 0;
    user_addr = 5'h07;
    for (int i = 0; i < 32; i++) begin
      step();
      got_v = {an, seg, dp}; exp_v = sb.pop_front(); n_checks++;
      if (got_v !== exp_v)
        $display("FAIL lead_zero e=%0d: got an/seg/dp %b/%h/%b want %b/%h/%b",
                 e, an, seg, dp, exp_v[11:8], exp_v[7:1], exp_v[0]);
      else n_pass++;
      if (m_tick && s_addr == 5'h07 && (m_digit == 2 || m_digit == 3)) begin
        seen++; n_checks++;
        if ((m_digit == 3 && {an, seg, dp} !== BLANK) ||
            (m_digit == 2 && {an, seg, dp} !== {4'b1011, 7'h78, 1'b0}))
          $display("FAIL lead_zero_digit%0d: got an/seg/dp %b/%h/%b", m_digit, an, seg, dp);
        else n_pass++;
      end
    end
    n_checks++;
    if (seen == 0) $display("FAIL lead_zero_seen: got 0 digit slots want >0"); else n_pass++;
  endtask

  task automatic test_midframe_change();
    int phase = 0;
    user_addr = 5'h13; byte_in = 8'hA5; reg_bits = 2'd0;
    for (int i = 0; i < 48 && phase < 4; i++) begin
      step();
      got_v = {an, seg, dp}; exp_v = sb.pop_front(); n_checks++;
      if (got_v !== exp_v)
        $display("FAIL midframe e=%0d: got an/seg/dp %b/%h/%b want %b/%h/%b",
                 e, an, seg, dp, exp_v[11:8], exp_v[7:1], exp_v[0]);
      else n_pass++;
      if (phase == 0 && m_tick && m_digit == 0 && s_byte == 8'hA5) phase = 1;
      else if (phase == 1 && m_tick && m_digit == 1) begin
        byte_in = 8'h3C; phase = 2;
      end else if (phase == 2 && m_digit == 1) begin
        n_checks++;
        if (seg !== 7'h08) $display("FAIL midframe_hold: got seg %h want 08", seg); else n_pass++;
      end else if (phase == 2 && m_tick && m_digit == 0) begin
        n_checks++;
        if (seg !== 7'h46) $display("FAIL midframe_d0: got seg %h want 46", seg); else n_pass++;
        phase = 3;
      end else if (phase == 3 && m_tick && m_digit == 1) begin
        n_checks++;
        if (seg !== 7'h30) $display("FAIL midframe_d1: got seg %h want 30", seg); else n_pass++;
        phase = 4;
      end
    end
    n_checks++;
    if (phase != 4) $display("FAIL midframe_timeout: got phase %0d want 4", phase); else n_pass++;
  endtask

  task automatic test_top_byte();
    int seen = 0;
    reg_bits = 2'd3; byte_in = 8'h00;
    for (int i = 0; i < 36; i++) begin
      step();
      got_v = {an, seg, dp}; exp_v = sb.pop_front(); n_checks++;
      if (got_v !== exp_v)
        $display("FAIL top_byte e=%0d: got an/seg/dp %b/%h/%b want %b/%h/%b",
                 e, an, seg, dp, exp_v[11:8], exp_v[7:1], exp_v[0]);
      else n_pass++;
      if (m_tick && s_bits == 2'd3 && s_byte == 8'h00 && m_digit < 2) begin
        seen++; n_checks++;
        if ((m_digit == 0 && {seg, dp} !== {7'h40, 1'b0}) ||
            (m_digit == 1 && {seg, dp} !== {7'h40, 1'b1}))
          $display("FAIL top_byte_digit%0d: got seg/dp %h/%b", m_digit, seg, dp);
        else n_pass++;
      end
    end
    n_checks++;
    if (seen == 0) $display("FAIL top_byte_seen: got 0 digit slots want >0"); else n_pass++;
    reg_bits = 2'd0; byte_in = 8'hA5;
  endtask

  task automatic test_disp_en();
    bit off_checked = 0;
    bit on_checked  = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 6)  disp_en = 1'b0;
      if (i == 16) disp_en = 1'b1;
      step();
      got_v = {an, seg, dp}; exp_v = sb.pop_front(); n_checks++;
      if (got_v !== exp_v)
        $display("FAIL disp_en e=%0d: got an/seg/dp %b/%h/%b want %b/%h/%b",
                 e, an, seg, dp, exp_v[11:8], exp_v[7:1], exp_v[0]);
      else n_pass++;
      if (i >= 6 && i < 16 && m_tick && !off_checked) begin
        off_checked = 1; n_checks++;
        if ({an, seg, dp} !== BLANK) $display("FAIL disp_off: got an %b want 1111", an); else n_pass++;
      end
      if (i >= 16 && m_tick && !on_checked) begin
        on_checked = 1; n_checks++;
        if (an !== ~(4'b0001 << m_digit))
          $display("FAIL disp_resume: got an %b want %b", an, ~(4'b0001 << m_digit));
        else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset();
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      got_v = {an, seg, dp}; exp_v = sb.pop_front(); n_checks++;
      if (got_v !== exp_v)
        $display("FAIL async_pre e=%0d: got an/seg/dp %b/%h/%b want %b/%h/%b",
                 e, an, seg, dp, exp_v[11:8], exp_v[7:1], exp_v[0]);
      else n_pass++;
      if (m_tick && m_digit == 2) found = 1;
    end
    n_checks++;
    if (!found) $display("FAIL async_find_digit2: got none want digit 2"); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({an, seg, dp} !== BLANK)
      $display("FAIL async_reset: got an/seg/dp %b/%h/%b want 1111/7f/1", an, seg, dp);
    else n_pass++;
    @(posedge CLK); #1;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      step();
      got_v = {an, seg, dp}; exp_v = sb.pop_front(); n_checks++;
      if (got_v !== exp_v)
        $display("FAIL async_post e=%0d: got an/seg/dp %b/%h/%b want %b/%h/%b",
                 e, an, seg, dp, exp_v[11:8], exp_v[7:1], exp_v[0]);
      else n_pass++;
      if (e == 3 || e == 4) begin
        n_checks++;
        if ((e == 3 && an !== 4'b1111) || (e == 4 && an !== 4'b1110))
          $display("FAIL async_first_digit e=%0d: got an %b", e, an);
        else n_pass++;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan();
    test_leading_zero();
    test_midframe_change();
    test_top_byte();
    test_disp_en();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_display_driver.md
Name: reg_display_driver

Overview:
- Downstream consumer of the processor's user debug byte (`register_out_user`) and the user's register selection (`user_addr`, `reg_bits`).
- Drives a 4-digit, time-multiplexed, common-anode seven-segment display.
- Digits 3..2 show the selected register number in hex. Digits 1..0 show the selected byte in hex.
- Inputs are snapshotted once per frame so a frame never shows mixed old/new values.

Parameters:
- REFRESH_DIV, 100000, CLK cycles each digit is lit; legal range 2..2^CNT_W.
- CNT_W, 17, prescaler counter width.

Ports:
- CLK  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- disp_en  input  1  1 = display on; 0 = all anodes off (scanning continues).
- user_addr  input  5  register number being displayed.
- reg_bits  input  2  byte-lane select, shown via decimal points.
- byte_in  input  8  byte from `register_out_user`.
- an  output  4  digit anodes, active-low, one-hot-low when lit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

Behaviour:
- Reset (reset=0, async) forces all of the following immediately:
  - prescaler=0, digit index idx=3, shadow regs=0.
  - an=4'b1111, seg=7'h7F, dp=1.
- Prescaler counts 0..REFRESH_DIV-1, then wraps to 0. `tick` is asserted in the cycle where prescaler==REFRESH_DIV-1.
- On tick, idx advances modulo 4 (3->0 wraps). Each digit is lit for exactly REFRESH_DIV cycles.
- Frame start is the tick where idx goes 3->0. On that edge:
  - shadow_addr<=user_addr, shadow_bits<=reg_bits, shadow_byte<=byte_in.
  - The digit-0 outputs driven on that same edge are decoded from the freshly sampled inputs, not the old shadow.
- Outputs are fully registered and update only on tick edges (and on reset). an, seg and dp always change on the same edge.
- Digit contents for the new idx:
  - 0: hex of shadow_byte[3:0].
  - 1: hex of shadow_byte[7:4].
  - 2: hex of shadow_addr[3:0].
  - 3: shadow_addr[4] shown as '1'; blanked (an[3]=1, seg=7'h7F) when shadow_addr[4]==0, i.e. leading-zero suppression.
- Lit anode: an = ~(4'b0001<<idx).
- Hex encoding (active-low gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- dp=0 on digit 2 (address/data separator). Also dp=0 on digit 0 when shadow_bits==3 (top byte marker). Otherwise dp=1.
- disp_en=0 at a tick edge: that edge drives an=4'b1111, seg=7'h7F, dp=1. idx, prescaler and snapshots continue normally.
- disp_en=1 again: display resumes at the next tick edge with the then-current idx.
- Changes to the inputs mid-frame are ignored until the next frame start.
- Reset mid-frame restarts from the reset state. The first digit-0 display appears REFRESH_DIV cycles after reset release.
- No combinational path from any input to any output.

Test Plan (REFRESH_DIV=4, CNT_W=3):
- Release reset with byte_in=8'hA5, user_addr=5'h13, reg_bits=0, disp_en=1. Expected:
  - an=1111 and seg=7F for 4 cycles.
  - Then an=1110/seg=12, an=1101/seg=08, an=1011/seg=30 with dp=0, an=0111/seg=79.
  - Each step lasts 4 cycles.
- user_addr=5'h07: digit 3 slot shows an=1111, seg=7F (blanked). Digit 2 shows seg=78, dp=0.
- Change byte_in from 8'hA5 to 8'h3C while idx=1. Expected:
  - Digit 1 keeps seg=08 for the rest of that frame.
  - The next frame shows digit0=46, digit1=30.
- reg_bits=3 with byte_in=8'h00: digit 0 shows seg=40, dp=0. Digit 1 shows dp=1.
- Drop disp_en for 10 cycles mid-frame. Expected:
  - an=1111 from the next tick edge.
  - Scan timing is unchanged: after re-enable, the lit digit equals the one expected from the uninterrupted tick count.
- Assert reset asynchronously between clock edges while digit 2 is lit: an=1111, seg=7F, dp=1 immediately, with no clock edge needed.
